// File: rtl/pmem_adapter_pkg.sv
// ============================================================================
// pmem_adapter_pkg: shared constants, state encoding and beat-index type
// Revision: 1.0
// ============================================================================
`default_nettype none

package pmem_adapter_pkg;

   localparam int LINE_WIDTH = 256;
   localparam int BEAT_WIDTH = 64;
   localparam int BEATS      = 4;
   localparam int S_OFFSET   = 5;
   localparam int CNT_WIDTH  = $clog2(BEATS);

   typedef logic [CNT_WIDTH-1:0] beat_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic [31:0] align_addr(input logic [31:0] addr);
      return {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
   endfunction

endpackage

`default_nettype wire

// File: rtl/line_beat_buffer.sv
// ============================================================================
// line_beat_buffer: line register with full-line load, per-beat fill, beat read
// Revision: 1.0
// ============================================================================
`default_nettype none

module line_beat_buffer
   import pmem_adapter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [LINE_WIDTH-1:0] load_line_i,
   input  logic                  fill_i,
   input  beat_idx_t             sel_i,
   input  logic [BEAT_WIDTH-1:0] fill_data_i,
   output logic [LINE_WIDTH-1:0] line_o,
   output logic [BEAT_WIDTH-1:0] beat_o
);

   logic [BEAT_WIDTH-1:0] w_beats [BEATS];

   for (genvar b = 0; b < BEATS; b++) begin : g_beat
      logic [BEAT_WIDTH-1:0] beat_q;

      // A full-line load takes precedence; the FSM never requests both at once.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            beat_q <= '0;
         end else if (load_i) begin
            beat_q <= load_line_i[b*BEAT_WIDTH +: BEAT_WIDTH];
         end else if (fill_i && (sel_i == beat_idx_t'(b))) begin
            beat_q <= fill_data_i;
         end
      end

      assign w_beats[b]                            = beat_q;
      assign line_o[b*BEAT_WIDTH +: BEAT_WIDTH]    = beat_q;
   end

   assign beat_o = w_beats[sel_i];

endmodule

`default_nettype wire

// File: rtl/pmem_line_adapter.sv
// ============================================================================
// pmem_line_adapter: 256-bit line requests to 4-beat 64-bit memory bursts
// Revision: 1.0
// ============================================================================
`default_nettype none

module pmem_line_adapter
   import pmem_adapter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pmem_read,
   input  logic                  pmem_write,
   input  logic [31:0]           pmem_address,
   input  logic [LINE_WIDTH-1:0] pmem_wdata,
   output logic [LINE_WIDTH-1:0] pmem_rdata,
   output logic                  pmem_resp,
   output logic                  burst_read,
   output logic                  burst_write,
   output logic [31:0]           burst_address,
   output logic [BEAT_WIDTH-1:0] burst_wdata,
   input  logic [BEAT_WIDTH-1:0] burst_rdata,
   input  logic                  burst_resp
);

   state_e                state_q, state_d;
   beat_idx_t             cnt_q, cnt_d;
   logic [31:0]           addr_q, addr_d;
   logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

   logic                  w_last_beat;
   logic                  w_load;
   logic                  w_fill;
   logic [LINE_WIDTH-1:0] w_line;
   logic [BEAT_WIDTH-1:0] w_beat;

   assign w_last_beat = (cnt_q == beat_idx_t'(BEATS-1));
   assign w_load      = (state_q == ST_IDLE) && pmem_write;
   assign w_fill      = (state_q == ST_READ) && burst_resp;

   line_beat_buffer u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (w_load),
      .load_line_i (pmem_wdata),
      .fill_i      (w_fill),
      .sel_i       (cnt_q),
      .fill_data_i (burst_rdata),
      .line_o      (w_line),
      .beat_o      (w_beat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (pmem_write || pmem_read) begin
               state_d = pmem_write ? ST_WRITE : ST_READ;
               cnt_d   = '0;
               addr_d  = align_addr(pmem_address);
            end
         end
         ST_READ: begin
            if (burst_resp) begin
               cnt_d = cnt_q + 1'b1;
               // The last beat bypasses the buffer so the line is visible in DONE.
               if (w_last_beat) begin
                  state_d = ST_DONE;
                  rdata_d = w_line;
                  rdata_d[LINE_WIDTH-1 -: BEAT_WIDTH] = burst_rdata;
               end
            end
         end
         ST_WRITE: begin
            if (burst_resp) begin
               cnt_d = cnt_q + 1'b1;
               if (w_last_beat) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      burst_read  = 1'b0;
      burst_write = 1'b0;
      pmem_resp   = 1'b0;
      burst_wdata = '0;
      case (state_q)
         ST_READ:  burst_read = 1'b1;
         ST_WRITE: begin
            burst_write = 1'b1;
            burst_wdata = w_beat;
         end
         ST_DONE:  pmem_resp = 1'b1;
         default:  ;
      endcase
   end

   assign burst_address = addr_q;
   assign pmem_rdata    = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_pmem_line_adapter.sv
// ============================================================================
// tb_pmem_line_adapter: directed table and sequence checks for pmem_line_adapter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pmem_line_adapter;

   logic         clk;
   logic         rst_n;
   logic         rd;
   logic         wr;
   logic [31:0]  addr;
   logic [255:0] wdata;
   logic [255:0] rdata;
   logic         resp;
   logic         br;
   logic         bw;
   logic [31:0]  baddr;
   logic [63:0]  bwdata;
   logic [63:0]  brdata;
   logic         bresp;

   int n_checks = 0;
   int n_err    = 0;

   pmem_line_adapter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pmem_read     (rd),
      .pmem_write    (wr),
      .pmem_address  (addr),
      .pmem_wdata    (wdata),
      .pmem_rdata    (rdata),
      .pmem_resp     (resp),
      .burst_read    (br),
      .burst_write   (bw),
      .burst_address (baddr),
      .burst_wdata   (bwdata),
      .burst_rdata   (brdata),
      .burst_resp    (bresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        rd;
      logic        bresp;
      logic [63:0] brdata;
      logic        e_br;
      logic        e_resp;
   } vec_t;

   vec_t        vecs [9];
   logic [63:0] wbeat [4];
   logic [63:0] dbeat [4];
   logic [63:0] cbeat [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      // Spurious burst_resp in IDLE, then a no-wait read of 0x1234.
      vecs[0] = '{1'b0, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 64'hBEEF_BEEF_BEEF_BEEF, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 64'h0,                   1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 64'h1111_1111_1111_1111, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 64'h2222_2222_2222_2222, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 64'h3333_3333_3333_3333, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 64'h4444_4444_4444_4444, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 64'h0,                   1'b0, 1'b0};

      wbeat[0] = 64'h0123_4567_89AB_CDEF;
      wbeat[1] = 64'hFEDC_BA98_7654_3210;
      wbeat[2] = 64'hA5A5_5A5A_C3C3_3C3C;
      wbeat[3] = 64'h0F0F_F0F0_1234_8765;
      dbeat[0] = 64'hD000_0000_0000_00D0;
      dbeat[1] = 64'hD111_1111_1111_11D1;
      dbeat[2] = 64'hD222_2222_2222_22D2;
      dbeat[3] = 64'hD333_3333_3333_33D3;
      cbeat[0] = 64'hC0C0_C0C0_C0C0_C0C0;
      cbeat[1] = 64'hC1C1_C1C1_C1C1_C1C1;
      cbeat[2] = 64'hC2C2_C2C2_C2C2_C2C2;
      cbeat[3] = 64'hC3C3_C3C3_C3C3_C3C3;

      rst_n  = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      addr   = '0;
      wdata  = '0;
      brdata = '0;
      bresp  = 1'b0;
      tick();
      tick();
      chk("rst_resp",   resp,   1'b0);
      chk("rst_rdata",  rdata,  256'h0);
      chk("rst_br",     br,     1'b0);
      chk("rst_bw",     bw,     1'b0);
      chk("rst_baddr",  baddr,  32'h0);
      chk("rst_bwdata", bwdata, 64'h0);
      rst_n = 1'b1;
      tick();

      // ---- table: spurious responses then read ----
      addr = 32'h0000_1234;
      for (int i = 0; i < 9; i++) begin
         rd     = vecs[i].rd;
         bresp  = vecs[i].bresp;
         brdata = vecs[i].brdata;
         tick();
         chk($sformatf("tbl_br[%0d]", i),   br,   vecs[i].e_br);
         chk($sformatf("tbl_resp[%0d]", i), resp, vecs[i].e_resp);
         chk($sformatf("tbl_bw[%0d]", i),   bw,   1'b0);
         if (vecs[i].e_br)
            chk($sformatf("tbl_baddr[%0d]", i), baddr, 32'h0000_1220);
      end
      chk("rd1_rdata", rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

      // ---- write with two stall cycles before every beat ----
      wr    = 1'b1;
      addr  = 32'h8000_00E0;
      wdata = {wbeat[3], wbeat[2], wbeat[1], wbeat[0]};
      bresp = 1'b0;
      tick();
      chk("wr_bw",    bw,    1'b1);
      chk("wr_br",    br,    1'b0);
      chk("wr_baddr", baddr, 32'h8000_00E0);
      for (int k = 0; k < 4; k++) begin
         bresp = 1'b0;
         for (int s = 0; s < 2; s++) begin
            chk($sformatf("wr_stall_wdata[%0d]", k), bwdata, wbeat[k]);
            chk($sformatf("wr_stall_resp[%0d]", k),  resp,   1'b0);
            tick();
         end
         chk($sformatf("wr_beat_wdata[%0d]", k), bwdata, wbeat[k]);
         chk($sformatf("wr_beat_bw[%0d]", k),    bw,     1'b1);
         bresp = 1'b1;
         tick();
      end
      chk("wr_resp",   resp, 1'b1);
      chk("wr_bw_end", bw,   1'b0);
      chk("wr_rdata_kept", rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
      wr    = 1'b0;
      bresp = 1'b0;
      tick();
      chk("wr_resp_once", resp, 1'b0);

      // ---- read and write both requested: write wins ----
      rd    = 1'b1;
      wr    = 1'b1;
      addr  = 32'h0000_0047;
      wdata = {4{64'h5555_AAAA_5555_AAAA}};
      bresp = 1'b1;
      tick();
      chk("both_baddr", baddr, 32'h0000_0040);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("both_br[%0d]", i), br, 1'b0);
         chk($sformatf("both_bw[%0d]", i), bw, 1'b1);
         tick();
      end
      chk("both_resp", resp, 1'b1);
      chk("both_br_done", br, 1'b0);
      rd    = 1'b0;
      wr    = 1'b0;
      bresp = 1'b0;
      tick();

      // ---- back-to-back read then write, memory always ready ----
      rd    = 1'b1;
      addr  = 32'h0000_0100;
      bresp = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b2b_br[%0d]", i), br, 1'b1);
         brdata = dbeat[i];
         tick();
      end
      chk("b2b_rd_resp",  resp,  1'b1);
      chk("b2b_rd_rdata", rdata, {dbeat[3], dbeat[2], dbeat[1], dbeat[0]});
      rd    = 1'b0;
      wr    = 1'b1;
      wdata = {4{64'h7777_0000_7777_0000}};
      tick();
      chk("b2b_idle_bw",   bw,   1'b0);
      chk("b2b_idle_resp", resp, 1'b0);
      tick();
      chk("b2b_wr_bw",     bw,     1'b1);
      chk("b2b_wr_wdata0", bwdata, 64'h7777_0000_7777_0000);
      for (int i = 0; i < 4; i++) tick();
      chk("b2b_wr_resp",  resp,  1'b1);
      chk("b2b_wr_rdata", rdata, {dbeat[3], dbeat[2], dbeat[1], dbeat[0]});
      wr    = 1'b0;
      bresp = 1'b0;
      tick();

      // ---- reset after two beats of a read ----
      rd    = 1'b1;
      addr  = 32'h0000_2000;
      bresp = 1'b1;
      tick();
      brdata = 64'hAAAA_AAAA_AAAA_AAAA;
      tick();
      brdata = 64'hBBBB_BBBB_BBBB_BBBB;
      tick();
      chk("abort_br_before", br, 1'b1);
      #2;
      rst_n = 1'b0;
      rd    = 1'b0;
      bresp = 1'b0;
      #1;
      chk("abort_br_async", br,    1'b0);
      chk("abort_rdata",    rdata, 256'h0);
      chk("abort_baddr",    baddr, 32'h0);
      tick();
      chk("abort_resp_rst", resp, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("abort_resp_after", resp, 1'b0);
      chk("abort_br_after",   br,   1'b0);

      rd    = 1'b1;
      addr  = 32'h0000_3010;
      bresp = 1'b1;
      tick();
      chk("new_baddr", baddr, 32'h0000_3000);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("new_resp_low[%0d]", i), resp, 1'b0);
         brdata = cbeat[i];
         tick();
      end
      chk("new_resp",  resp,  1'b1);
      chk("new_rdata", rdata, {cbeat[3], cbeat[2], cbeat[1], cbeat[0]});
      rd    = 1'b0;
      bresp = 1'b0;
      tick();
      chk("new_idle_resp", resp, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire
